// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one external 4-bit logic unit among NUM_REQ requesters.
// Define LOGIC_ARB_OPCHECK_EN to flag illegal opcodes (rsp_err=1, rsp_y=0).
module logic_unit_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [4*NUM_REQ-1:0] req_opcode,
   input  logic [4*NUM_REQ-1:0] req_a,
   input  logic [4*NUM_REQ-1:0] req_b,
   output logic [3:0]           lu_opcode,
   output logic [3:0]           lu_a,
   output logic [3:0]           lu_b,
   input  logic [3:0]           lu_y,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [3:0]           rsp_y,
   output logic                 rsp_err,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t          state, state_nxt;
   logic [ID_W-1:0] rr_ptr;
   logic            gnt_found;
   logic [ID_W-1:0] gnt_id;
   logic            hs;
   logic [3:0]      op_p0, a_p0, b_p0;
   logic [ID_W-1:0] id_p0;
   logic [3:0]      res_y;
   logic            res_err;

   function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return ID_W'(sum);
   endfunction

   // Scan downward so the smallest offset from rr_ptr is the last (winning) assignment.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_valid[rr_index(rr_ptr, k)]) begin
            gnt_found = 1'b1;
            gnt_id    = rr_index(rr_ptr, k);
         end
      end
   end

   assign hs = (state == IDLE) && gnt_found;

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      lu_opcode = '0;
      lu_a      = '0;
      lu_b      = '0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (gnt_found) begin
               req_ready = NUM_REQ'(1) << gnt_id;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            lu_opcode = op_p0;
            lu_a      = a_p0;
            lu_b      = b_p0;
            state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         rr_ptr <= '0;
      end else begin
         state <= state_nxt;
         if (hs) rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
   end

   // Stage p0: operands captured at the request handshake
   always_ff @(posedge clk) begin
      if (hs) begin
         op_p0 <= req_opcode[{gnt_id, 2'b00} +: 4];
         a_p0  <= req_a[{gnt_id, 2'b00} +: 4];
         b_p0  <= req_b[{gnt_id, 2'b00} +: 4];
         id_p0 <= gnt_id;
      end
   end

`ifdef LOGIC_ARB_OPCHECK_EN
   function automatic logic op_legal(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd7);
   endfunction

   assign res_err = !op_legal(op_p0);
   assign res_y   = res_err ? 4'b0000 : lu_y;
`else
   assign res_err = 1'b0;
   assign res_y   = lu_y;
`endif

   // Result stage: captured at the end of EXEC, held through RESP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_y   <= '0;
         rsp_id  <= '0;
         rsp_err <= 1'b0;
      end else if (state == EXEC) begin
         rsp_y   <= res_y;
         rsp_id  <= id_p0;
         rsp_err <= res_err;
      end
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: behavioural model with per-cycle compare
// plus directed vectors with hand-computed literal responses.
`timescale 1ns/1ps
module tb_logic_unit_arbiter;
   localparam int NR = 2;
   localparam int IW = 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NR-1:0]   req_valid, req_ready;
   logic [4*NR-1:0] req_opcode, req_a, req_b;
   logic [3:0]      lu_opcode, lu_a, lu_b, lu_y;
   logic            rsp_valid, rsp_ready, rsp_err, busy;
   logic [IW-1:0]   rsp_id;
   logic [3:0]      rsp_y;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;
   int req_cnt [NR];
   int log_id [$];
   logic [3:0] log_y [$];
   logic log_err [$];
   logic [NR-1:0] gseen;

   always #5 clk = ~clk;

   logic_unit_arbiter #(.NUM_REQ(NR), .ID_W(IW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
      .lu_opcode(lu_opcode), .lu_a(lu_a), .lu_b(lu_b), .lu_y(lu_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy)
   );

   // External logic unit; illegal opcodes return a recognisable filler value.
   function automatic logic [3:0] lu_ref(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         4'b0001: return a & b;
         4'b0010: return a | b;
         4'b0011: return a ^ b;
         4'b0100: return ~(a & b);
         4'b0101: return ~(a | b);
         4'b0110: return ~(a ^ b);
         4'b0111: return ~a;
         default: return 4'b1001;
      endcase
   endfunction

   function automatic bit op_ok(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd7);
   endfunction

   assign lu_y = lu_ref(lu_opcode, lu_a, lu_b);

   function automatic logic [3:0] exp_y(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
`ifdef LOGIC_ARB_OPCHECK_EN
      return op_ok(op) ? lu_ref(op, a, b) : 4'b0000;
`else
      return lu_ref(op, a, b);
`endif
   endfunction

   function automatic logic exp_err(input logic [3:0] op);
`ifdef LOGIC_ARB_OPCHECK_EN
      return !op_ok(op);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int pick(input logic [NR-1:0] v, input int rr);
      for (int k = 0; k < NR; k++)
         if (v[(rr + k) % NR]) return (rr + k) % NR;
      return -1;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: phase 0 waiting for a grant, 1 computing, 2 presenting the result.
   int         m_phase, m_rr, m_id, m_rid, m_g;
   logic [3:0] m_op, m_a, m_b, m_y;
   logic       m_err;

   assign m_g = pick(req_valid, m_rr);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0; m_rr <= 0; m_id <= 0; m_rid <= 0;
         m_op <= '0; m_a <= '0; m_b <= '0; m_y <= '0; m_err <= 1'b0;
      end else if (m_phase == 0) begin
         if (m_g >= 0) begin
            m_phase <= 1;
            m_id    <= m_g;
            m_rr    <= (m_g + 1) % NR;
            m_op    <= req_opcode[4*m_g +: 4];
            m_a     <= req_a[4*m_g +: 4];
            m_b     <= req_b[4*m_g +: 4];
         end
      end else if (m_phase == 1) begin
         m_phase <= 2;
         m_rid   <= m_id;
         m_y     <= exp_y(m_op, m_a, m_b);
         m_err   <= exp_err(m_op);
      end else if (rsp_ready) begin
         m_phase <= 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", 8'(req_ready), (m_phase == 0 && m_g >= 0) ? 8'(1 << m_g) : 8'd0);
         chk("busy", 8'(busy), 8'(m_phase != 0));
         chk("rsp_valid", 8'(rsp_valid), 8'(m_phase == 2));
         chk("rsp_y", 8'(rsp_y), 8'(m_y));
         chk("rsp_id", 8'(rsp_id), 8'(m_rid));
         chk("rsp_err", 8'(rsp_err), 8'(m_err));
         chk("lu_opcode", 8'(lu_opcode), (m_phase == 1) ? 8'(m_op) : 8'd0);
         chk("lu_a", 8'(lu_a), (m_phase == 1) ? 8'(m_a) : 8'd0);
         chk("lu_b", 8'(lu_b), (m_phase == 1) ? 8'(m_b) : 8'd0);
      end
   end

   task automatic set_req(input int i, input logic [3:0] op, input logic [3:0] a,
                          input logic [3:0] b, input int cnt);
      req_opcode[4*i +: 4] = op;
      req_a[4*i +: 4]      = a;
      req_b[4*i +: 4]      = b;
      req_cnt[i]           = cnt;
      req_valid[i]         = 1'b1;
   endtask

   task automatic clear_log();
      log_id.delete();
      log_y.delete();
      log_err.delete();
   endtask

   // Requesters keep valid high until granted req_cnt times; accepted responses are logged.
   task automatic drive_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         gseen = req_ready;
         if (rsp_valid && rsp_ready) begin
            log_id.push_back(int'(rsp_id));
            log_y.push_back(rsp_y);
            log_err.push_back(rsp_err);
         end
         @(posedge clk); #1;
         for (int i = 0; i < NR; i++) begin
            if (gseen[i]) begin
               if (req_cnt[i] > 0) req_cnt[i]--;
               if (req_cnt[i] == 0) req_valid[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic chk_log(input int idx, input int id, input logic [3:0] y, input logic err,
                          input string name);
      if (idx >= log_id.size()) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: response %0d missing, got %0d responses", name, idx, log_id.size());
      end else begin
         chk({name, "_id"}, 8'(log_id[idx]), 8'(id));
         chk({name, "_y"}, 8'(log_y[idx]), 8'(y));
         chk({name, "_err"}, 8'(log_err[idx]), 8'(err));
      end
   endtask

   task automatic do_reset();
      req_valid = '0;
      for (int i = 0; i < NR; i++) req_cnt[i] = 0;
      @(posedge clk); #2 rst_n = 1'b0;
      @(posedge clk); #2;
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
      chk("rst_rsp_y", 8'(rsp_y), 8'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      int gcyc, rcyc;
      rst_n = 1'b1; req_valid = '0; req_opcode = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
      for (int i = 0; i < NR; i++) req_cnt[i] = 0;
      #2 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      do_reset();

      // Single AND request: result two cycles after the grant cycle
      clear_log();
      set_req(0, 4'b0001, 4'b1101, 4'b0110, 1);
      gcyc = -1; rcyc = -1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (req_ready[0] && gcyc < 0) gcyc = c;
         if (rsp_valid && rcyc < 0) begin
            rcyc = c;
            chk("t1_y", 8'(rsp_y), 8'b0100);
            chk("t1_id", 8'(rsp_id), 8'd0);
            chk("t1_err", 8'(rsp_err), 8'd0);
         end
         @(posedge clk); #1;
         if (gcyc == c) req_valid[0] = 1'b0;
      end
      if (gcyc < 0 || rcyc < 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL t1_latency: grant cycle %0d response cycle %0d, timed out", gcyc, rcyc);
      end else begin
         chk("t1_latency", 8'(rcyc - gcyc), 8'd2);
      end

      // Simultaneous requests, req0 re-requests while pending
      do_reset(); clear_log();
      set_req(0, 4'b0011, 4'b1101, 4'b0110, 2);
      set_req(1, 4'b0010, 4'b1101, 4'b0110, 1);
      drive_cycles(14);
      chk("t2_count", 8'(log_id.size()), 8'd3);
      chk_log(0, 0, 4'b1011, 1'b0, "t2_r0");
      chk_log(1, 1, 4'b1111, 1'b0, "t2_r1");
      chk_log(2, 0, 4'b1011, 1'b0, "t2_r2");

      // Backpressure with a second requester waiting
      do_reset(); clear_log();
      rsp_ready = 1'b0;
      set_req(0, 4'b0100, 4'b1101, 4'b0110, 1);
      set_req(1, 4'b0001, 4'b1111, 4'b1111, 1);
      drive_cycles(2);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("t3_valid", 8'(rsp_valid), 8'd1);
         chk("t3_y", 8'(rsp_y), 8'b1011);
         chk("t3_busy", 8'(busy), 8'd1);
         chk("t3_ready", 8'(req_ready), 8'd0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      drive_cycles(8);
      chk("t3_count", 8'(log_id.size()), 8'd2);
      chk_log(0, 0, 4'b1011, 1'b0, "t3_r0");
      chk_log(1, 1, 4'b1111, 1'b0, "t3_r1");

      // NOT ignores B
      do_reset(); clear_log();
      set_req(0, 4'b0111, 4'b1101, 4'b1111, 1);
      drive_cycles(5);
      set_req(0, 4'b0111, 4'b1101, 4'b0000, 1);
      drive_cycles(5);
      chk_log(0, 0, 4'b0010, 1'b0, "t4_b1111");
      chk_log(1, 0, 4'b0010, 1'b0, "t4_b0000");

      // Illegal opcodes 1000 and 0000
      clear_log();
      set_req(1, 4'b1000, 4'b0101, 4'b0011, 1);
      drive_cycles(5);
      set_req(0, 4'b0000, 4'b1111, 4'b1111, 1);
      drive_cycles(5);
`ifdef LOGIC_ARB_OPCHECK_EN
      chk_log(0, 1, 4'b0000, 1'b1, "t5_op8");
      chk_log(1, 0, 4'b0000, 1'b1, "t5_op0");
`else
      chk_log(0, 1, 4'b1001, 1'b0, "t5_op8");
      chk_log(1, 0, 4'b1001, 1'b0, "t5_op0");
`endif

      // Reset during EXEC discards the op and restores requester 0 priority
      do_reset(); clear_log();
      set_req(0, 4'b0001, 4'b1111, 4'b1111, 1);
      @(negedge clk);
      chk("t6_grant", 8'(req_ready), 8'b01);
      @(posedge clk); #1;
      req_valid[0] = 1'b0; req_cnt[0] = 0;
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("t6_busy", 8'(busy), 8'd0);
      chk("t6_valid", 8'(rsp_valid), 8'd0);
      chk("t6_lu_op", 8'(lu_opcode), 8'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      drive_cycles(3);
      chk("t6_no_rsp", 8'(log_id.size()), 8'd0);
      set_req(0, 4'b0001, 4'b1100, 4'b1010, 1);
      set_req(1, 4'b0010, 4'b0001, 4'b0010, 1);
      drive_cycles(10);
      chk_log(0, 0, 4'b1000, 1'b0, "t6_r0");
      chk_log(1, 1, 4'b0011, 1'b0, "t6_r1");

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
